// File: rtl/simon_pkg.sv
// Shared Simon 128/256 definitions: default round count, word width, FSM states
// and the round function f(). Optional decrypt path is enabled by SIMON_CORE_DECRYPT_EN.
package simon_pkg;

    localparam int SIMON_ROUNDS = 72;
    localparam int WORD_W       = 64;
    localparam int BLOCK_W      = 2 * WORD_W;
    localparam int KEY_IDX_W    = 7;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // f(x) = (x<<<1 & x<<<8) ^ x<<<2
    function automatic logic [WORD_W-1:0] simon_f(input logic [WORD_W-1:0] x);
        logic [WORD_W-1:0] r1;
        logic [WORD_W-1:0] r2;
        logic [WORD_W-1:0] r8;
        r1 = {x[WORD_W-2:0], x[WORD_W-1]};
        r2 = {x[WORD_W-3:0], x[WORD_W-1 -: 2]};
        r8 = {x[WORD_W-9:0], x[WORD_W-1 -: 8]};
        return (r1 & r8) ^ r2;
    endfunction

endpackage

// File: rtl/simon_core_if.sv
// Block-level handshake bundle for simon_core: block input and result output.
// Packing for both blocks: upper word = x, lower word = y.
interface simon_core_if;
    import simon_pkg::*;

    logic               in_valid;
    logic               in_ready;
    logic [BLOCK_W-1:0] in_block;
    logic               out_valid;
    logic               out_ready;
    logic [BLOCK_W-1:0] out_block;

    // valid/ready: a transfer happens on a rising edge where both are high; the
    // source keeps valid and payload stable until then, and valid never waits on ready.
    modport master (
        output in_valid, in_block, out_ready,
        input  in_ready, out_valid, out_block
    );

    modport slave (
        input  in_valid, in_block, out_ready,
        output in_ready, out_valid, out_block
    );

endinterface

// File: rtl/simon_key_store.sv
// Round-key register file: one synchronous write port, one combinational read port.
// Contents are deliberately not reset; the core tracks validity separately.
module simon_key_store
    import simon_pkg::*;
#(
    parameter int DEPTH = SIMON_ROUNDS
) (
    input  logic                 clk,
    input  logic                 wr_en,
    input  logic [KEY_IDX_W-1:0] wr_addr,
    input  logic [WORD_W-1:0]    wr_data,
    input  logic [KEY_IDX_W-1:0] rd_addr,
    output logic [WORD_W-1:0]    rd_data
);

    logic [WORD_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/simon_core.sv
// Iterative Simon 128/256 block core: one round per clock, round keys from an internal store.
// Defining SIMON_CORE_DECRYPT_EN adds the decrypt input and the reverse-key decryption path.
module simon_core
    import simon_pkg::*;
#(
    parameter int ROUNDS = SIMON_ROUNDS
) (
    input  logic                 clk,
    input  logic                 res_n,
    input  logic                 key_wr_en,
    input  logic [KEY_IDX_W-1:0] key_rnd,
    input  logic [WORD_W-1:0]    key_data,
    input  logic                 key_done,
`ifdef SIMON_CORE_DECRYPT_EN
    input  logic                 decrypt,
`endif
    simon_core_if.slave          bus,
    output logic                 keys_ok,
    output logic                 key_err,
    output state_t               dbg_state,
    output logic [KEY_IDX_W-1:0] dbg_rc
);

    localparam logic [KEY_IDX_W-1:0] LAST_RC  = KEY_IDX_W'(ROUNDS - 1);
    localparam logic [KEY_IDX_W-1:0] NUM_KEYS = KEY_IDX_W'(ROUNDS);

    state_t               state_q;
    state_t               state_d;
    logic [WORD_W-1:0]    x_q;
    logic [WORD_W-1:0]    x_d;
    logic [WORD_W-1:0]    y_q;
    logic [WORD_W-1:0]    y_d;
    logic [KEY_IDX_W-1:0] rc_q;
    logic [KEY_IDX_W-1:0] rc_d;
    logic                 dec_q;
    logic                 dec_d;
    logic                 dec_in;
    logic [BLOCK_W-1:0]   out_q;
    logic [BLOCK_W-1:0]   out_d;
    logic                 keys_ok_q;
    logic                 key_err_q;
    logic                 in_ready_w;
    logic                 accept;
    logic                 key_wr_ok;
    logic [KEY_IDX_W-1:0] key_rd_idx;
    logic [WORD_W-1:0]    key_rd_data;
    logic [WORD_W-1:0]    round_x;

`ifdef SIMON_CORE_DECRYPT_EN
    assign dec_in = decrypt;
`else
    assign dec_in = 1'b0;
`endif

    // Key writes only land while idle, so a running block always sees a stable key set.
    assign key_wr_ok  = key_wr_en && (key_rnd < NUM_KEYS) && (state_q == IDLE);
    assign in_ready_w = keys_ok_q && (state_q == IDLE);
    assign accept     = bus.in_valid && in_ready_w;
    assign key_rd_idx = dec_q ? (LAST_RC - rc_q) : rc_q;
    assign round_x    = y_q ^ simon_f(x_q) ^ key_rd_data;

    simon_key_store #(
        .DEPTH (ROUNDS)
    ) u_key_store (
        .clk     (clk),
        .wr_en   (key_wr_ok),
        .wr_addr (key_rnd),
        .wr_data (key_data),
        .rd_addr (key_rd_idx),
        .rd_data (key_rd_data)
    );

    // A rewrite of key 0 marks a new schedule in progress; it beats key_done in the same cycle.
    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            keys_ok_q <= 1'b0;
            key_err_q <= 1'b0;
        end else begin
            if (key_wr_en && !key_wr_ok) begin
                key_err_q <= 1'b1;
            end
            if (key_wr_ok && (key_rnd == '0)) begin
                keys_ok_q <= 1'b0;
            end else if (key_done) begin
                keys_ok_q <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            state_q <= IDLE;
            x_q     <= '0;
            y_q     <= '0;
            rc_q    <= '0;
            dec_q   <= 1'b0;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            rc_q    <= rc_d;
            dec_q   <= dec_d;
            out_q   <= out_d;
        end
    end

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        rc_d    = rc_q;
        dec_d   = dec_q;
        out_d   = out_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = RUN;
                    rc_d    = '0;
                    dec_d   = dec_in;
                    // Decryption is the forward round applied to the half-swapped block.
                    x_d     = dec_in ? bus.in_block[WORD_W-1:0] : bus.in_block[BLOCK_W-1:WORD_W];
                    y_d     = dec_in ? bus.in_block[BLOCK_W-1:WORD_W] : bus.in_block[WORD_W-1:0];
                end
            end
            RUN: begin
                x_d  = round_x;
                y_d  = x_q;
                rc_d = rc_q + 7'd1;
                if (rc_q == LAST_RC) begin
                    state_d = DONE;
                    rc_d    = '0;
                    out_d   = dec_q ? {x_q, round_x} : {round_x, x_q};
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.in_ready  = in_ready_w;
    assign bus.out_valid = (state_q == DONE);
    assign bus.out_block = out_q;
    assign keys_ok       = keys_ok_q;
    assign key_err       = key_err_q;
    assign dbg_state     = state_q;
    assign dbg_rc        = rc_q;

endmodule

// File: tb/tb_simon_core.sv
// Bench for simon_core: published Simon 128/256 vector, key-store corner cases,
// backpressure and mid-run reset. Decrypt vectors are added when SIMON_CORE_DECRYPT_EN is defined.
module tb_simon_core;
    import simon_pkg::*;

    localparam int           NR    = SIMON_ROUNDS;
    localparam logic [127:0] TV_PT = 128'h74206e69206d6f6f_6d69732061207369;
    localparam logic [127:0] TV_CT = 128'h8d2b5579afc8a3a0_3bf72a87efe7b868;
    localparam logic [63:0]  Z4    = 64'h3dc94c3a046d678b;

    logic                 clk;
    logic                 res_n;
    logic                 key_wr_en;
    logic [KEY_IDX_W-1:0] key_rnd;
    logic [WORD_W-1:0]    key_data;
    logic                 key_done;
    logic                 decrypt;
    logic                 keys_ok;
    logic                 key_err;
    state_t               dbg_state;
    logic [KEY_IDX_W-1:0] dbg_rc;

    simon_core_if bus ();

    simon_core dut (
        .clk       (clk),
        .res_n     (res_n),
        .key_wr_en (key_wr_en),
        .key_rnd   (key_rnd),
        .key_data  (key_data),
        .key_done  (key_done),
`ifdef SIMON_CORE_DECRYPT_EN
        .decrypt   (decrypt),
`endif
        .bus       (bus),
        .keys_ok   (keys_ok),
        .key_err   (key_err),
        .dbg_state (dbg_state),
        .dbg_rc    (dbg_rc)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [63:0] rk [NR];

    typedef struct {
        string        name;
        logic [127:0] blk;
        logic         dec;
        logic [127:0] exp;
    } vec_t;

    vec_t vecs[$];

    // scoreboard: expected results queued at accept, popped at output handshake
    logic [127:0] exp_q[$];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] rol(input logic [63:0] v, input int n);
        return (v << n) | (v >> (64 - n));
    endfunction

    function automatic logic [63:0] ror(input logic [63:0] v, input int n);
        return (v >> n) | (v << (64 - n));
    endfunction

    task automatic expand_keys();
        logic [63:0] t;
        logic [63:0] z;
        z = Z4;
        rk[0] = 64'h0706050403020100;
        rk[1] = 64'h0f0e0d0c0b0a0908;
        rk[2] = 64'h1716151413121110;
        rk[3] = 64'h1f1e1d1c1b1a1918;
        for (int i = 4; i < NR; i++) begin
            t     = ror(rk[i-1], 3) ^ rk[i-3];
            t     = t ^ ror(t, 1);
            rk[i] = ~rk[i-4] ^ t ^ {63'b0, z[(i-4) % 62]} ^ 64'd3;
        end
    endtask

    function automatic logic [127:0] model_enc(input logic [127:0] blk);
        logic [63:0] x;
        logic [63:0] y;
        logic [63:0] t;
        x = blk[127:64];
        y = blk[63:0];
        for (int r = 0; r < NR; r++) begin
            t = x;
            x = y ^ ((rol(x, 1) & rol(x, 8)) ^ rol(x, 2)) ^ rk[r];
            y = t;
        end
        return {x, y};
    endfunction

    // driver tasks
    task automatic apply_reset();
        @(negedge clk);
        res_n = 1'b0;
        @(negedge clk);
        res_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic write_key(input int idx, input logic [63:0] data);
        @(negedge clk);
        key_wr_en = 1'b1;
        key_rnd   = KEY_IDX_W'(idx);
        key_data  = data;
        @(negedge clk);
        key_wr_en = 1'b0;
    endtask

    task automatic pulse_key_done();
        @(negedge clk);
        key_done = 1'b1;
        @(negedge clk);
        key_done = 1'b0;
    endtask

    // Ends 1 time unit after the accept edge.
    task automatic accept_block(input logic [127:0] blk, input logic dec, input logic [127:0] exp,
                                input string name);
        int guard;
        guard = 0;
        @(negedge clk);
        while (!bus.in_ready && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        check({name, "_in_ready"}, 128'(bus.in_ready), 128'd1);
        bus.in_block = blk;
        bus.in_valid = 1'b1;
        decrypt      = dec;
        exp_q.push_back(exp);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    // Called 1 time unit after an edge; lat0 = edges already elapsed since accept.
    task automatic wait_result(input string name, input int lat0);
        int           lat;
        logic [127:0] exp;
        lat = lat0;
        while (!bus.out_valid && lat < 200) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check({name, "_latency"}, 128'(lat), 128'(NR));
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : 128'hx;
        check({name, "_out_block"}, bus.out_block, exp);
    endtask

    task automatic release_result(input string name);
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        check({name, "_idle_after_hs"}, 128'(dbg_state), 128'(IDLE));
        check({name, "_out_valid_low"}, 128'(bus.out_valid), 128'd0);
    endtask

    task automatic run_block(input vec_t v);
        accept_block(v.blk, v.dec, v.exp, v.name);
        wait_result(v.name, 0);
        release_result(v.name);
    endtask

    initial begin
        #1_000_000;
        checks++;
        errors++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        int seen;
        res_n         = 1'b0;
        key_wr_en     = 1'b0;
        key_rnd       = '0;
        key_data      = '0;
        key_done      = 1'b0;
        decrypt       = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_block  = '0;
        bus.out_ready = 1'b0;

        expand_keys();
        vecs.push_back('{"tv_enc", TV_PT, 1'b0, TV_CT});
        vecs.push_back('{"zero_enc", 128'd0, 1'b0, model_enc(128'd0)});
        vecs.push_back('{"ones_enc", {128{1'b1}}, 1'b0, model_enc({128{1'b1}})});
        vecs.push_back('{"mix_enc", 128'h0123456789abcdef_fedcba9876543210, 1'b0,
                         model_enc(128'h0123456789abcdef_fedcba9876543210)});
`ifdef SIMON_CORE_DECRYPT_EN
        vecs.push_back('{"tv_dec", TV_CT, 1'b1, TV_PT});
        vecs.push_back('{"zero_dec", model_enc(128'd0), 1'b1, 128'd0});
`endif

        // reset values, sampled while reset is held
        repeat (2) @(negedge clk);
        check("rst_out_valid", 128'(bus.out_valid), 128'd0);
        check("rst_in_ready", 128'(bus.in_ready), 128'd0);
        check("rst_keys_ok", 128'(keys_ok), 128'd0);
        check("rst_key_err", 128'(key_err), 128'd0);
        check("rst_out_block", bus.out_block, 128'd0);
        check("rst_state", 128'(dbg_state), 128'(IDLE));
        check("rst_rc", 128'(dbg_rc), 128'd0);
        res_n = 1'b1;
        @(negedge clk);
        check("post_rst_in_ready", 128'(bus.in_ready), 128'd0);

        for (int i = 0; i < NR; i++) begin
            write_key(i, rk[i]);
        end
        check("keys_ok_before_done", 128'(keys_ok), 128'd0);
        check("in_ready_before_done", 128'(bus.in_ready), 128'd0);
        pulse_key_done();
        check("keys_ok_after_done", 128'(keys_ok), 128'd1);
        check("in_ready_after_done", 128'(bus.in_ready), 128'd1);
        check("key_err_after_load", 128'(key_err), 128'd0);

        foreach (vecs[i]) begin
            run_block(vecs[i]);
        end

        // backpressure: result held for 10 cycles, then back-to-back accept
        accept_block(TV_PT, 1'b0, TV_CT, "bp");
        wait_result("bp", 0);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            check("bp_out_block_stable", bus.out_block, TV_CT);
            check("bp_in_ready_low", 128'(bus.in_ready), 128'd0);
            check("bp_out_valid_held", 128'(bus.out_valid), 128'd1);
        end
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        check("bp_in_ready_after_hs", 128'(bus.in_ready), 128'd1);
        bus.in_block = vecs[1].blk;
        bus.in_valid = 1'b1;
        decrypt      = 1'b0;
        exp_q.push_back(vecs[1].exp);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        check("bp_next_accepted", 128'(dbg_state), 128'(RUN));
        wait_result("bp_next", 0);
        release_result("bp_next");

        // key write and key_done during RUN must not reach the running block
        accept_block(TV_PT, 1'b0, TV_CT, "kwr");
        @(posedge clk);
        #1;
        key_wr_en = 1'b1;
        key_rnd   = 7'd5;
        key_data  = 64'hdeadbeefcafef00d;
        key_done  = 1'b1;
        @(posedge clk);
        #1;
        key_wr_en = 1'b0;
        key_done  = 1'b0;
        check("kwr_key_err", 128'(key_err), 128'd1);
        check("kwr_still_run", 128'(dbg_state), 128'(RUN));
        wait_result("kwr", 2);
        release_result("kwr");
        run_block('{"kwr_rerun", TV_PT, 1'b0, TV_CT});

        // key-store validity rules; reset clears the sticky error, not the store
        apply_reset();
        check("rst2_key_err", 128'(key_err), 128'd0);
        check("rst2_keys_ok", 128'(keys_ok), 128'd0);
        pulse_key_done();
        check("rst2_keys_ok_done", 128'(keys_ok), 128'd1);
        write_key(0, rk[0]);
        check("rewrite0_keys_ok", 128'(keys_ok), 128'd0);
        check("rewrite0_in_ready", 128'(bus.in_ready), 128'd0);
        repeat (3) @(negedge clk);
        check("rewrite0_in_ready_hold", 128'(bus.in_ready), 128'd0);
        @(negedge clk);
        key_wr_en = 1'b1;
        key_rnd   = 7'd0;
        key_data  = rk[0];
        key_done  = 1'b1;
        @(negedge clk);
        key_wr_en = 1'b0;
        key_done  = 1'b0;
        check("clear_wins_keys_ok", 128'(keys_ok), 128'd0);
        pulse_key_done();
        check("redone_keys_ok", 128'(keys_ok), 128'd1);
        write_key(72, 64'h0123456789abcdef);
        check("bad_idx_key_err", 128'(key_err), 128'd1);
        check("bad_idx_keys_ok", 128'(keys_ok), 128'd1);
        run_block('{"after_bad_idx", TV_PT, 1'b0, TV_CT});

        // reset at round 30 aborts the block with no output
        accept_block(TV_PT, 1'b0, TV_CT, "abort");
        repeat (30) @(posedge clk);
        #1;
        check("abort_rc_30", 128'(dbg_rc), 128'd30);
        #3;
        res_n = 1'b0;
        #1;
        check("abort_state_idle", 128'(dbg_state), 128'(IDLE));
        check("abort_keys_ok", 128'(keys_ok), 128'd0);
        check("abort_out_valid", 128'(bus.out_valid), 128'd0);
        check("abort_rc_zero", 128'(dbg_rc), 128'd0);
        void'(exp_q.pop_back());
        @(negedge clk);
        res_n = 1'b1;
        seen  = 0;
        repeat (100) begin
            @(posedge clk);
            #1;
            if (bus.out_valid) seen = 1;
        end
        check("abort_no_output", 128'(seen), 128'd0);
        check("abort_state_final", 128'(dbg_state), 128'(IDLE));
        check("abort_in_ready", 128'(bus.in_ready), 128'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
